// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the RV32M multiply sequencer.
//   mul_op_e  : RV32M multiply flavour, encoded as the funct3 low bits
//   state_e   : sequencer state
//   op_sign_a : rs1 is treated as signed when extended to XLEN+1 bits
//   op_sign_b : rs2 is treated as signed when extended to XLEN+1 bits
//   op_hi     : op returns the upper half of the 2*XLEN product
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    ADD  = 2'b10,
    DONE = 2'b11
  } state_e;

  // MUL only needs the low half, which is identical for any signedness. Treating
  // it as signed x signed makes its cache key match MULH on the same operands.
  function automatic logic op_sign_a(input mul_op_e op);
    return (op == MUL) || (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_sign_b(input mul_op_e op);
    return (op == MUL) || (op == MULH);
  endfunction

  function automatic logic op_hi(input mul_op_e op);
    return (op != MUL);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response bus of the multiply sequencer.
//   in_valid/in_ready      : request handshake
//   in_op, in_a, in_b      : operation and rs1/rs2 values
//   in_tag                 : opaque tag (rd index) returned with the result
//   out_valid/out_ready    : response handshake
//   out_result, out_tag    : selected product half and its tag
// master = issuing side (EX stage), slave = the sequencer.
interface mul_seq_ctrl_if
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  mul_op_e          in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mul_prod_cache.sv
// One-entry product cache keyed by the two (XLEN+1)-bit extended operands.
//   clk                 : clock
//   clear               : synchronous invalidate (tied to reset)
//   lookup_x/lookup_y   : key to look up (combinational)
//   hit/hit_prod        : entry valid and key matches / stored product
//   wr_en, wr_x/y/prod  : write a new entry on the rising edge
// The key carries the extension bit, so the same bit pattern used signed and
// unsigned (negative operand) gives two different keys.
module mul_prod_cache #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [XLEN:0]     lookup_x,
  input  logic [XLEN:0]     lookup_y,
  output logic              hit,
  output logic [2*XLEN-1:0] hit_prod,
  input  logic              wr_en,
  input  logic [XLEN:0]     wr_x,
  input  logic [XLEN:0]     wr_y,
  input  logic [2*XLEN-1:0] wr_prod
);
  logic              valid_q, valid_d;
  logic [XLEN:0]     x_q, x_d;
  logic [XLEN:0]     y_q, y_d;
  logic [2*XLEN-1:0] prod_q, prod_d;

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    prod_d  = prod_q;
    if (wr_en) begin
      valid_d = 1'b1;
      x_d     = wr_x;
      y_d     = wr_y;
      prod_d  = wr_prod;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      prod_q  <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      prod_q  <= prod_d;
    end
  end

  assign hit      = valid_q && (x_q == lookup_x) && (y_q == lookup_y);
  assign hit_prod = prod_q;
endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the external radix-4 Booth / Wallace-tree multiplier (RV32M
// MUL/MULH/MULHSU/MULHU).
//   clk, rst            : clock, synchronous active-high reset
//   flush               : kill the in-flight op
//   bus (slave)         : request/response handshake, see mul_seq_ctrl_if
//   mdp_x/mdp_y         : registered extended operands to the Booth encoder
//   mdp_sum/mdp_carry   : tree outputs; product = sum + carry mod 2^(2*XLEN)
// A miss runs IDLE->CALC->ADD->DONE; a zero operand or a product-cache hit
// goes straight from IDLE to DONE with the product already known.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  mul_seq_ctrl_if.slave     bus,
  output logic [XLEN:0]     mdp_x,
  output logic [XLEN:0]     mdp_y,
  input  logic [2*XLEN-1:0] mdp_sum,
  input  logic [2*XLEN-1:0] mdp_carry
);
  state_e            state_q, state_d;
  mul_op_e           op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN:0]     mdp_x_q, mdp_x_d;
  logic [XLEN:0]     mdp_y_q, mdp_y_d;
  logic [2*XLEN-1:0] sum_q, sum_d;
  logic [2*XLEN-1:0] carry_q, carry_d;
  logic [2*XLEN-1:0] prod_q, prod_d;

  logic              accept;
  logic              zero_in;
  logic [XLEN:0]     x_in, y_in;
  logic              cache_hit;
  logic [2*XLEN-1:0] cache_prod;
  logic              cache_wr;

  // in_ready is combinational so a flush or reset blocks acceptance in the same cycle.
  assign bus.in_ready = (state_q == IDLE) && !flush && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  assign x_in    = {bus.in_a[XLEN-1] & op_sign_a(bus.in_op), bus.in_a};
  assign y_in    = {bus.in_b[XLEN-1] & op_sign_b(bus.in_op), bus.in_b};
  assign zero_in = (bus.in_a == '0) || (bus.in_b == '0);

  mul_prod_cache #(.XLEN(XLEN)) u_cache (
    .clk      (clk),
    .clear    (rst),
    .lookup_x (x_in),
    .lookup_y (y_in),
    .hit      (cache_hit),
    .hit_prod (cache_prod),
    .wr_en    (cache_wr),
    .wr_x     (mdp_x_q),
    .wr_y     (mdp_y_q),
    .wr_prod  (prod_d)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    mdp_x_d  = mdp_x_q;
    mdp_y_d  = mdp_y_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    prod_d   = prod_q;
    cache_wr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = bus.in_op;
          tag_d = bus.in_tag;
          if (zero_in) begin
            prod_d  = '0;
            state_d = DONE;
          end else if (cache_hit) begin
            prod_d  = cache_prod;
            state_d = DONE;
          end else begin
            // Only a miss loads the tree operands, so the tree does not toggle
            // on zero or cached ops.
            mdp_x_d = x_in;
            mdp_y_d = y_in;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        sum_d   = mdp_sum;
        carry_d = mdp_carry;
        state_d = ADD;
      end
      ADD: begin
        prod_d   = sum_q + carry_q;
        cache_wr = !flush;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= MUL;
      tag_q   <= '0;
      mdp_x_q <= '0;
      mdp_y_q <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      mdp_x_q <= mdp_x_d;
      mdp_y_q <= mdp_y_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      prod_q  <= prod_d;
    end
  end

  assign mdp_x          = mdp_x_q;
  assign mdp_y          = mdp_y_q;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_tag    = tag_q;
  assign bus.out_result = op_hi(op_q) ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed RV32M cases plus randomized ops
// checked against an arithmetic reference model with its own cache bookkeeping.
module tb_mul_seq_ctrl;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [32:0] mdp_x, mdp_y;
  logic [63:0] mdp_sum, mdp_carry;
  logic [63:0] split = 64'd0;

  mul_seq_ctrl_if #(.XLEN(32), .TAG_W(5)) bus ();

  mul_seq_ctrl #(.XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .mdp_x     (mdp_x),
    .mdp_y     (mdp_y),
    .mdp_sum   (mdp_sum),
    .mdp_carry (mdp_carry)
  );

  always #5 clk = ~clk;

  // Stand-in for the Booth tree: signed 33x33 product split into sum + carry.
  logic [63:0] tree_p;
  always_comb begin
    tree_p    = {{31{mdp_x[32]}}, mdp_x} * {{31{mdp_y[32]}}, mdp_y};
    mdp_carry = split;
    mdp_sum   = tree_p - split;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid = 1'b0;
  logic [63:0] m_va, m_vb;          // numeric values of the cached operands
  bit          exp_active = 1'b0;
  logic [31:0] exp_res;
  logic [4:0]  exp_tag;

  function automatic logic [63:0] ival(input logic [31:0] v, input bit s);
    return s ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  // Result from RV32M semantics; latency from zero/cache rules. The cache key is
  // the numeric value each operand takes in the Booth datapath (MUL counts as signed).
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] er, output int el, output bit miss,
                       output logic [63:0] ka, output logic [63:0] kb);
    logic [63:0] full;
    bit zero, hit;
    full = ival(a, op == 2'd1 || op == 2'd2) * ival(b, op == 2'd1);
    er   = (op == 2'd0) ? full[31:0] : full[63:32];
    ka   = ival(a, op != 2'd3);
    kb   = ival(b, op <= 2'd1);
    zero = (a == 0) || (b == 0);
    hit  = !zero && m_valid && (ka == m_va) && (kb == m_vb);
    el   = (zero || hit) ? 1 : 3;
    miss = !zero && !hit;
  endtask

  task automatic new_split();
    split = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom(), $urandom()};
  endtask

  // Compare process: every cycle the DUT claims a result, it must be the expected one.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      chk(exp_active, "unexpected_out_valid", 64'(bus.out_valid), 64'(exp_active));
      if (exp_active) begin
        chk(bus.out_result == exp_res, "out_result", 64'(bus.out_result), 64'(exp_res));
        chk(bus.out_tag == exp_tag, "out_tag", 64'(bus.out_tag), 64'(exp_tag));
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = mul_op_e'(op);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    chk(bus.in_ready == 1'b1, "in_ready_idle", 64'(bus.in_ready), 64'd1);
  endtask

  // Full transaction from a negedge in IDLE back to a negedge in IDLE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold, input bit poke,
                        input bit lit_en, input logic [31:0] lit_res, input int lit_lat);
    logic [31:0] er; int el; bit miss; int lat; logic [63:0] ka, kb;
    model(op, a, b, er, el, miss, ka, kb);
    if (lit_en) begin
      chk(er == lit_res, "model_pin_result", 64'(er), 64'(lit_res));
      chk(el == lit_lat, "model_pin_latency", 64'(el), 64'(lit_lat));
    end
    new_split();
    drive(op, a, b, tag);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_active = 1'b1; exp_res = er; exp_tag = tag;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.out_valid || lat > 8) break;
      chk(bus.in_ready == 1'b0, "busy_in_ready", 64'(bus.in_ready), 64'd0);
      if (lat == 1 && miss)
        chk(mdp_x == ka[32:0] && mdp_y == kb[32:0], "mdp_operands", {31'd0, mdp_x}, ka);
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.in_op    = mul_op_e'(2'($urandom_range(0, 3)));
        bus.in_a     = $urandom();
        bus.in_b     = $urandom();
        bus.in_tag   = 5'($urandom());
      end
    end
    bus.in_valid = 1'b0;
    chk(lat == el, "latency", 64'(lat), 64'(el));
    if (lit_en) chk(bus.out_result == lit_res, "literal_result", 64'(bus.out_result), 64'(lit_res));
    if (miss) begin m_valid = 1'b1; m_va = ka; m_vb = kb; end
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    chk(bus.out_valid == 1'b0, "valid_after_handshake", 64'(bus.out_valid), 64'd0);
    chk(bus.in_ready == 1'b1, "ready_after_handshake", 64'(bus.in_ready), 64'd1);
    $display("op=%0d a=%08h b=%08h tag=%0d lat=%0d result=%08h", op, a, b, tag, lat, er);
  endtask

  // Accept an op, flush it `at` cycles later (1 = first cycle after accept).
  task automatic flush_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int at);
    logic [31:0] er; int el; bit miss; logic [63:0] ka, kb;
    model(op, a, b, er, el, miss, ka, kb);
    new_split();
    drive(op, a, b, tag);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_active = 1'b1; exp_res = er; exp_tag = tag;
    repeat (at) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_active = 1'b0;
    // A flush in DONE comes after the ADD that already filled the cache.
    if (miss && at >= 3) begin m_valid = 1'b1; m_va = ka; m_vb = kb; end
    @(negedge clk);
    chk(bus.out_valid == 1'b0, "flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk(bus.in_ready == 1'b1, "flush_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(negedge clk);
    $display("flushed op=%0d a=%08h b=%08h at=%0d", op, a, b, at);
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk(bus.in_ready == 1'b0, {tagname, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk(bus.out_valid == 1'b0, {tagname, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk(bus.out_result == 32'd0, {tagname, "_out_result"}, 64'(bus.out_result), 64'd0);
    chk(bus.out_tag == 5'd0, {tagname, "_out_tag"}, 64'(bus.out_tag), 64'd0);
    chk(mdp_x == 33'd0 && mdp_y == 33'd0, {tagname, "_mdp"}, {31'd0, mdp_x}, 64'd0);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb, pa, pb;
    logic [31:0] er; int el; bit miss; logic [63:0] ka, kb;
    bus.in_valid = 1'b0; bus.in_op = MUL; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk(bus.in_ready == 1'b1, "ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Directed cases
    run_op(2'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0, 1'b1, 1'b1, 32'hFFFF_FFEB, 3);
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 1'b0, 1'b1, 32'hFFFF_FFFE, 3);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 1'b0, 1'b1, 32'h0000_0001, 3);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, 1'b0, 1'b1, 32'h0000_0000, 1);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd5, 0, 1'b0, 1'b1, 32'h4000_0000, 3);
    run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 3);
    run_op(2'd0, 32'd0, 32'h1234_5678, 5'd7, 0, 1'b0, 1'b1, 32'h0000_0000, 1);
    run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1);
    run_op(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 5, 1'b1, 1'b0, 32'd0, 0);

    // Flush in CALC, then in ADD; repeats must miss
    flush_op(2'd0, 32'h0000_1111, 32'h0000_2222, 5'd10, 1);
    run_op(2'd0, 32'h0000_1111, 32'h0000_2222, 5'd11, 0, 1'b0, 1'b1, 32'h0246_8642, 3);
    flush_op(2'd3, 32'd3, 32'd5, 5'd12, 2);
    run_op(2'd3, 32'd3, 32'd5, 5'd13, 0, 1'b0, 1'b1, 32'd0, 3);

    // Reset while in CALC invalidates the cache
    new_split();
    drive(2'd1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd14);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    chk(bus.in_ready == 1'b1, "ready_after_mid_reset", 64'(bus.in_ready), 64'd1);
    run_op(2'd3, 32'd3, 32'd5, 5'd15, 0, 1'b0, 1'b1, 32'd0, 3);

    // Randomized ops; reuse of the previous operands exercises cache hits/misses
    pa = 32'd1; pb = 32'd1;
    for (int i = 0; i < 200; i++) begin
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin ra = pa; rb = pb; end
      else begin ra = rand_opnd(); rb = rand_opnd(); end
      if ($urandom_range(0, 9) == 0) begin
        model(rop, ra, rb, er, el, miss, ka, kb);
        flush_op(rop, ra, rb, 5'($urandom()), $urandom_range(1, el));
      end else begin
        run_op(rop, ra, rb, 5'($urandom()), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 1'b0, 32'd0, 0);
      end
      pa = ra; pb = rb;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
